load_store_mem_access_stage: RTL and testbench

Memory-access stage downstream of the load/store address generation stage.
- Accepts one computed address plus store data per transaction over a valid/ready handshake.
- Drives the data memory over a req/ack handshake.
- Returns either extracted, extended load data or a store-completion token to register writeback, tagged with the originating instruction tag and Rd.
- One transaction in flight; one writeback holding register.

---
 rtl/ld_str_mem_pkg.sv | 37 +++
 rtl/ld_str_byte_lane_align.sv | 48 ++++
 rtl/load_store_mem_access_stage.sv | 207 ++++++++++++++++++++
 tb/tb_load_store_mem_access_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_str_mem_pkg.sv
// Shared definitions for the load/store memory-access stage.
//   - Access size encodings as carried on req_size_in
//   - FSM state encoding for the stage controller
//   - Byte-lane width constants (32-bit data, four byte lanes)
//   - is_misaligned(): alignment check applied when a request is accepted
package ld_str_mem_pkg;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int LANES  = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // The reserved size is treated as misaligned so it aborts without a bus access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         SZ_WORD: mis = (off != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ld_str_byte_lane_align.sv
// Combinational little-endian byte-lane steering.
//   size_i, off_i       : access size and byte offset (addr[1:0])
//   signed_i            : sign-extend byte/half loads
//   store_data_i        : register value, payload in the low bits
//   rdata_i             : raw memory read word
//   be_o                : byte enables for the access
//   wdata_o             : store data replicated onto every candidate lane
//   load_data_o         : extracted and extended load result
module ld_str_byte_lane_align
   import ld_str_mem_pkg::*;
(
   input  logic [1:0]        size_i,
   input  logic [1:0]        off_i,
   input  logic              signed_i,
   input  logic [WORD_W-1:0] store_data_i,
   input  logic [WORD_W-1:0] rdata_i,
   output logic [LANES-1:0]  be_o,
   output logic [WORD_W-1:0] wdata_o,
   output logic [WORD_W-1:0] load_data_o
);

   logic [BYTE_W-1:0]   load_byte;
   logic [2*BYTE_W-1:0] load_half;

   // Offsets are byte counts; the part-select bases are the offset scaled to bits.
   assign load_byte = rdata_i[{off_i, 3'b000} +: BYTE_W];
   assign load_half = rdata_i[{off_i[1], 4'b0000} +: 2*BYTE_W];

   always_comb begin
      be_o        = 4'b1111;
      wdata_o     = store_data_i;
      load_data_o = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            be_o        = 4'b0001 << off_i;
            wdata_o     = {LANES{store_data_i[BYTE_W-1:0]}};
            load_data_o = {{(WORD_W-BYTE_W){signed_i & load_byte[BYTE_W-1]}}, load_byte};
         end
         SZ_HALF: begin
            be_o        = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o     = {2{store_data_i[2*BYTE_W-1:0]}};
            load_data_o = {{(WORD_W-2*BYTE_W){signed_i & load_half[2*BYTE_W-1]}}, load_half};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_mem_access_stage.sv
// Load/store memory-access stage. Takes one address-generated request at a time,
// performs the data-memory access over req/ack, and presents the result in a single
// writeback holding register.
//   clk_in / reset_in               : clock, synchronous active-low reset
//   req_*                           : request handshake from address generation
//   mem_*                           : data memory request/ack interface
//   wb_*                            : writeback result handshake
module load_store_mem_access_stage
   import ld_str_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4,
   parameter int RD_W   = 4
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              req_valid_in,
   output logic              req_ready_out,
   input  logic [ADDR_W-1:0] req_addr_in,
   input  logic [DATA_W-1:0] req_store_data_in,
   input  logic              req_is_load_in,
   input  logic [1:0]        req_size_in,
   input  logic              req_signed_in,
   input  logic [TAG_W-1:0]  req_tag_in,
   input  logic [RD_W-1:0]   req_rd_addr_in,
   output logic              mem_req_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [3:0]        mem_be_out,
   output logic [DATA_W-1:0] mem_wdata_out,
   input  logic              mem_ack_in,
   input  logic [DATA_W-1:0] mem_rdata_in,
   input  logic              mem_err_in,
   output logic              wb_valid_out,
   input  logic              wb_ready_in,
   output logic [TAG_W-1:0]  wb_tag_out,
   output logic [RD_W-1:0]   wb_rd_addr_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic              wb_is_load_out,
   output logic              wb_abort_out
);

   state_e            state_q, state_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              wb_valid_q, wb_valid_d, wb_is_load_q, wb_is_load_d;
   logic              wb_abort_q, wb_abort_d;
   logic [TAG_W-1:0]  wb_tag_q, wb_tag_d, pend_tag_q, pend_tag_d;
   logic [RD_W-1:0]   wb_rd_q, wb_rd_d, pend_rd_q, pend_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [1:0]        pend_size_q, pend_size_d, pend_off_q, pend_off_d;
   logic              pend_signed_q, pend_signed_d, pend_is_load_q, pend_is_load_d;

   logic              accept, in_mem;
   logic [1:0]        ln_size, ln_off;
   logic              ln_signed;
   logic [3:0]        ln_be;
   logic [DATA_W-1:0] ln_wdata, ln_load;

   assign req_ready_out = reset_in & ((state_q == ST_IDLE) | ((state_q == ST_WB) & wb_ready_in));
   assign accept        = req_valid_in & req_ready_out;

   // One lane aligner serves both directions: while in MEM it extracts load data for
   // the latched request; otherwise it shapes the incoming request (no accept in MEM).
   assign in_mem    = (state_q == ST_MEM);
   assign ln_size   = in_mem ? pend_size_q   : req_size_in;
   assign ln_off    = in_mem ? pend_off_q    : req_addr_in[1:0];
   assign ln_signed = in_mem ? pend_signed_q : req_signed_in;

   ld_str_byte_lane_align u_lane (
      .size_i       (ln_size),
      .off_i        (ln_off),
      .signed_i     (ln_signed),
      .store_data_i (req_store_data_in),
      .rdata_i      (mem_rdata_in),
      .be_o         (ln_be),
      .wdata_o      (ln_wdata),
      .load_data_o  (ln_load)
   );

   always_comb begin
      state_d        = state_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_be_d       = mem_be_q;
      mem_wdata_d    = mem_wdata_q;
      wb_valid_d     = wb_valid_q;
      wb_tag_d       = wb_tag_q;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      wb_is_load_d   = wb_is_load_q;
      wb_abort_d     = wb_abort_q;
      pend_tag_d     = pend_tag_q;
      pend_rd_d      = pend_rd_q;
      pend_size_d    = pend_size_q;
      pend_off_d     = pend_off_q;
      pend_signed_d  = pend_signed_q;
      pend_is_load_d = pend_is_load_q;

      case (state_q)
         ST_MEM: begin
            if (mem_ack_in) begin
               state_d      = ST_WB;
               mem_req_d    = 1'b0;
               wb_valid_d   = 1'b1;
               wb_tag_d     = pend_tag_q;
               wb_rd_d      = pend_rd_q;
               wb_abort_d   = mem_err_in;
               wb_is_load_d = pend_is_load_q & ~mem_err_in;
               wb_data_d    = (pend_is_load_q & ~mem_err_in) ? ln_load : '0;
            end
         end
         ST_WB: begin
            if (wb_ready_in) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b0;
            end
         end
         default: ;
      endcase

      // Accept overrides the WB retirement above, giving back-to-back issue.
      if (accept) begin
         pend_tag_d     = req_tag_in;
         pend_rd_d      = req_rd_addr_in;
         pend_size_d    = req_size_in;
         pend_off_d     = req_addr_in[1:0];
         pend_signed_d  = req_signed_in;
         pend_is_load_d = req_is_load_in;
         if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
            state_d      = ST_WB;
            wb_valid_d   = 1'b1;
            wb_tag_d     = req_tag_in;
            wb_rd_d      = req_rd_addr_in;
            wb_abort_d   = 1'b1;
            wb_is_load_d = 1'b0;
            wb_data_d    = '0;
         end else begin
            state_d     = ST_MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = ~req_is_load_in;
            mem_addr_d  = {req_addr_in[ADDR_W-1:2], 2'b00};
            mem_be_d    = ln_be;
            mem_wdata_d = ln_wdata;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_q        <= ST_IDLE;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_be_q       <= '0;
         mem_wdata_q    <= '0;
         wb_valid_q     <= 1'b0;
         wb_tag_q       <= '0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
         wb_is_load_q   <= 1'b0;
         wb_abort_q     <= 1'b0;
         pend_tag_q     <= '0;
         pend_rd_q      <= '0;
         pend_size_q    <= '0;
         pend_off_q     <= '0;
         pend_signed_q  <= 1'b0;
         pend_is_load_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_be_q       <= mem_be_d;
         mem_wdata_q    <= mem_wdata_d;
         wb_valid_q     <= wb_valid_d;
         wb_tag_q       <= wb_tag_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         wb_is_load_q   <= wb_is_load_d;
         wb_abort_q     <= wb_abort_d;
         pend_tag_q     <= pend_tag_d;
         pend_rd_q      <= pend_rd_d;
         pend_size_q    <= pend_size_d;
         pend_off_q     <= pend_off_d;
         pend_signed_q  <= pend_signed_d;
         pend_is_load_q <= pend_is_load_d;
      end
   end

   assign mem_req_out    = mem_req_q;
   assign mem_we_out     = mem_we_q;
   assign mem_addr_out   = mem_addr_q;
   assign mem_be_out     = mem_be_q;
   assign mem_wdata_out  = mem_wdata_q;
   assign wb_valid_out   = wb_valid_q;
   assign wb_tag_out     = wb_tag_q;
   assign wb_rd_addr_out = wb_rd_q;
   assign wb_data_out    = wb_data_q;
   assign wb_is_load_out = wb_is_load_q;
   assign wb_abort_out   = wb_abort_q;

endmodule

// File: tb/tb_load_store_mem_access_stage.sv
// Bench for the load/store memory-access stage: directed scenarios followed by
// randomized transactions checked against an arithmetic reference model.
module tb_load_store_mem_access_stage;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        req_valid_in, req_ready_out;
   logic [31:0] req_addr_in, req_store_data_in;
   logic        req_is_load_in, req_signed_in;
   logic [1:0]  req_size_in;
   logic [3:0]  req_tag_in, req_rd_addr_in;
   logic        mem_req_out, mem_we_out;
   logic [31:0] mem_addr_out, mem_wdata_out;
   logic [3:0]  mem_be_out;
   logic        mem_ack_in, mem_err_in;
   logic [31:0] mem_rdata_in;
   logic        wb_valid_out, wb_ready_in;
   logic [3:0]  wb_tag_out, wb_rd_addr_out;
   logic [31:0] wb_data_out;
   logic        wb_is_load_out, wb_abort_out;

   int ncmp = 0;
   int nmis = 0;

   always #5 clk_in = ~clk_in;

   load_store_mem_access_stage #(.ADDR_W(32), .DATA_W(32), .TAG_W(4), .RD_W(4)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_addr_in(req_addr_in), .req_store_data_in(req_store_data_in),
      .req_is_load_in(req_is_load_in), .req_size_in(req_size_in),
      .req_signed_in(req_signed_in), .req_tag_in(req_tag_in),
      .req_rd_addr_in(req_rd_addr_in),
      .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
      .mem_addr_out(mem_addr_out), .mem_be_out(mem_be_out),
      .mem_wdata_out(mem_wdata_out), .mem_ack_in(mem_ack_in),
      .mem_rdata_in(mem_rdata_in), .mem_err_in(mem_err_in),
      .wb_valid_out(wb_valid_out), .wb_ready_in(wb_ready_in),
      .wb_tag_out(wb_tag_out), .wb_rd_addr_out(wb_rd_addr_out),
      .wb_data_out(wb_data_out), .wb_is_load_out(wb_is_load_out),
      .wb_abort_out(wb_abort_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #2;
   endtask

   // Reference model: plain arithmetic on sizes in bytes.
   function automatic logic mdl_mis(input logic [1:0] sz, input logic [31:0] a);
      int nbytes;
      if (sz == 2'd3) return 1'b1;
      nbytes = 1 << sz;
      return (a % nbytes) != 0;
   endfunction

   function automatic logic [3:0] mdl_be(input logic [1:0] sz, input logic [31:0] a);
      int o;
      o = a % 4;
      if (sz == 2'd0) return 4'(1 << o);
      if (sz == 2'd1) return 4'(3 << o);
      return 4'hF;
   endfunction

   function automatic logic [31:0] mdl_wdata(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
      if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic [31:0] a,
                                            input logic sg, input logic [31:0] rd);
      logic [31:0] v;
      int o;
      o = a % 4;
      if (sz == 2'd0) begin
         v = (rd >> (8 * o)) % 256;
         if (sg && v >= 128) v = v - 32'd256;
      end else if (sz == 2'd1) begin
         v = (rd >> (8 * o)) % 65536;
         if (sg && v >= 32768) v = v - 32'd65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // One complete transaction from IDLE back to IDLE.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] d,
                         input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [3:0] tg, input logic [3:0] rd,
                         input logic [31:0] rdat, input int waits, input logic err,
                         input int wbdly);
      logic [31:0] exp_data;
      req_addr_in = a; req_store_data_in = d; req_is_load_in = ld; req_size_in = sz;
      req_signed_in = sg; req_tag_in = tg; req_rd_addr_in = rd; req_valid_in = 1'b1;
      #1;
      chk({nm, " req_ready"}, 32'(req_ready_out), 32'd1);
      step();
      req_valid_in = 1'b0;
      req_addr_in = $urandom; req_store_data_in = $urandom;
      if (mdl_mis(sz, a)) begin
         chk({nm, " mis mem_req"}, 32'(mem_req_out), 32'd0);
         chk({nm, " mis wb_valid"}, 32'(wb_valid_out), 32'd1);
         chk({nm, " mis abort"}, 32'(wb_abort_out), 32'd1);
         chk({nm, " mis is_load"}, 32'(wb_is_load_out), 32'd0);
         chk({nm, " mis data"}, wb_data_out, 32'd0);
      end else begin
         chk({nm, " mem_req"}, 32'(mem_req_out), 32'd1);
         chk({nm, " mem_we"}, 32'(mem_we_out), 32'(!ld));
         chk({nm, " mem_addr"}, mem_addr_out, a & ~32'd3);
         chk({nm, " mem_be"}, 32'(mem_be_out), 32'(mdl_be(sz, a)));
         if (!ld) chk({nm, " mem_wdata"}, mem_wdata_out, mdl_wdata(sz, d));
         for (int i = 0; i < waits; i++) begin
            mem_rdata_in = $urandom;
            step();
            chk({nm, " wait mem_req"}, 32'(mem_req_out), 32'd1);
            chk({nm, " wait mem_addr"}, mem_addr_out, a & ~32'd3);
            chk({nm, " wait mem_be"}, 32'(mem_be_out), 32'(mdl_be(sz, a)));
            chk({nm, " wait wb_valid"}, 32'(wb_valid_out), 32'd0);
         end
         mem_ack_in = 1'b1; mem_rdata_in = rdat; mem_err_in = err;
         step();
         mem_ack_in = 1'b0; mem_err_in = 1'b0; mem_rdata_in = $urandom;
         exp_data = (ld && !err) ? mdl_load(sz, a, sg, rdat) : 32'd0;
         chk({nm, " mem_req drop"}, 32'(mem_req_out), 32'd0);
         chk({nm, " wb_valid"}, 32'(wb_valid_out), 32'd1);
         chk({nm, " abort"}, 32'(wb_abort_out), 32'(err));
         chk({nm, " is_load"}, 32'(wb_is_load_out), 32'(ld && !err));
         chk({nm, " wb_data"}, wb_data_out, exp_data);
      end
      chk({nm, " wb_tag"}, 32'(wb_tag_out), 32'(tg));
      chk({nm, " wb_rd"}, 32'(wb_rd_addr_out), 32'(rd));
      for (int i = 0; i < wbdly; i++) begin
         step();
         chk({nm, " hold wb_valid"}, 32'(wb_valid_out), 32'd1);
         chk({nm, " hold wb_tag"}, 32'(wb_tag_out), 32'(tg));
      end
      wb_ready_in = 1'b1;
      step();
      wb_ready_in = 1'b0;
      chk({nm, " wb retire"}, 32'(wb_valid_out), 32'd0);
   endtask

   initial begin
      logic [31:0] a, d, rdat;
      logic [1:0]  sz;
      reset_in = 1'b0; req_valid_in = 1'b0; req_addr_in = '0; req_store_data_in = '0;
      req_is_load_in = 1'b0; req_size_in = '0; req_signed_in = 1'b0; req_tag_in = '0;
      req_rd_addr_in = '0; mem_ack_in = 1'b0; mem_rdata_in = '0; mem_err_in = 1'b0;
      wb_ready_in = 1'b0;

      // Reset state
      step(); step();
      chk("rst mem_req", 32'(mem_req_out), 32'd0);
      chk("rst mem_we", 32'(mem_we_out), 32'd0);
      chk("rst mem_addr", mem_addr_out, 32'd0);
      chk("rst mem_be", 32'(mem_be_out), 32'd0);
      chk("rst mem_wdata", mem_wdata_out, 32'd0);
      chk("rst wb_valid", 32'(wb_valid_out), 32'd0);
      chk("rst wb_data", wb_data_out, 32'd0);
      chk("rst req_ready", 32'(req_ready_out), 32'd0);
      reset_in = 1'b1;
      #1;
      chk("rst release ready", 32'(req_ready_out), 32'd1);

      // Directed scenarios
      run_op("strb", 32'h1003, 32'h0000_00A5, 1'b0, 2'd0, 1'b0, 4'd3, 4'd5, 32'h0, 0, 1'b0, 0);
      chk("strb be const", 32'(mdl_be(2'd0, 32'h1003)), 32'h8);
      run_op("ldrsh", 32'h2002, 32'h0, 1'b1, 2'd1, 1'b1, 4'd9, 4'd12, 32'h8001_1234, 3, 1'b0, 0);
      run_op("ldr_mis", 32'h3001, 32'h0, 1'b1, 2'd2, 1'b0, 4'd4, 4'd2, 32'h0, 0, 1'b0, 1);
      run_op("ld_err", 32'h4000, 32'h0, 1'b1, 2'd2, 1'b0, 4'd6, 4'd1, 32'hDEAD_BEEF, 1, 1'b1, 0);
      run_op("size11", 32'h5000, 32'h0, 1'b1, 2'd3, 1'b0, 4'd7, 4'd7, 32'h0, 0, 1'b0, 0);

      // Reset held for three cycles while a load waits in MEM
      req_addr_in = 32'h40; req_is_load_in = 1'b1; req_size_in = 2'd2; req_valid_in = 1'b1;
      step();
      req_valid_in = 1'b0;
      chk("midrst mem_req before", 32'(mem_req_out), 32'd1);
      reset_in = 1'b0;
      #1;
      chk("midrst req_ready", 32'(req_ready_out), 32'd0);
      step();
      chk("midrst mem_req", 32'(mem_req_out), 32'd0);
      chk("midrst wb_valid", 32'(wb_valid_out), 32'd0);
      step(); step();
      chk("midrst held ready", 32'(req_ready_out), 32'd0);
      chk("midrst held wb_valid", 32'(wb_valid_out), 32'd0);
      reset_in = 1'b1;
      #1;
      chk("midrst release ready", 32'(req_ready_out), 32'd1);

      // Back-to-back with a stalled writeback consumer
      req_addr_in = 32'h100; req_store_data_in = 32'h1122_3344; req_is_load_in = 1'b0;
      req_size_in = 2'd2; req_signed_in = 1'b0; req_tag_in = 4'd1; req_rd_addr_in = 4'd3;
      req_valid_in = 1'b1;
      step();
      req_valid_in = 1'b0;
      mem_ack_in = 1'b1;
      step();
      mem_ack_in = 1'b0;
      chk("b2b first wb_valid", 32'(wb_valid_out), 32'd1);
      req_addr_in = 32'h206; req_is_load_in = 1'b1; req_size_in = 2'd1; req_signed_in = 1'b0;
      req_tag_in = 4'd2; req_rd_addr_in = 4'd7; req_valid_in = 1'b1;
      #1;
      chk("b2b stall ready", 32'(req_ready_out), 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("b2b hold wb_valid", 32'(wb_valid_out), 32'd1);
         chk("b2b hold wb_tag", 32'(wb_tag_out), 32'd1);
         chk("b2b hold mem_req", 32'(mem_req_out), 32'd0);
         chk("b2b hold ready", 32'(req_ready_out), 32'd0);
      end
      wb_ready_in = 1'b1;
      #1;
      chk("b2b ready with wb_ready", 32'(req_ready_out), 32'd1);
      step();
      wb_ready_in = 1'b0; req_valid_in = 1'b0;
      chk("b2b second mem_req", 32'(mem_req_out), 32'd1);
      chk("b2b second we", 32'(mem_we_out), 32'd0);
      chk("b2b second addr", mem_addr_out, 32'h204);
      chk("b2b second be", 32'(mem_be_out), 32'hC);
      chk("b2b first retired", 32'(wb_valid_out), 32'd0);
      mem_ack_in = 1'b1; mem_rdata_in = 32'hBEEF_0000;
      step();
      mem_ack_in = 1'b0;
      chk("b2b second wb_data", wb_data_out, 32'h0000_BEEF);
      chk("b2b second wb_tag", 32'(wb_tag_out), 32'd2);
      wb_ready_in = 1'b1;
      step();
      wb_ready_in = 1'b0;

      // Randomized transactions
      for (int n = 0; n < 60; n++) begin
         sz = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         d = $urandom;
         rdat = $urandom;
         run_op("rnd", a, d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                4'($urandom), 4'($urandom), rdat, $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
